// File: rtl/calculator_arbiter.sv
// calculator_arbiter
//   Shares one calculator ALU between two instruction requesters. A
//   round-robin grant picks one requester per cycle. The decoded fields are
//   registered onto the ALU inputs in the issue stage. The ALU result is
//   captured in the response stage and returned on the owner's channel.
//   Both stages stall when the owner's Resp_Ready is low.
//
// Ports
//   CLK, Reset                      clock, async active-high reset
//   Req_Valid_k / Req_Instruction_k requester k instruction channel
//   Req_Ready_k                     requester k accepted this cycle
//   Alu_Operation/_Operand_1/_2     registered fields to the ALU
//   Alu_Result                      combinational ALU result
//   Resp_Valid_k / Resp_Ready_k     requester k response handshake
//   Resp_Result                     shared response data
//   Busy                            issue or response stage occupied
//
// Build option
//   CALC_ARB_FIXED_PRIORITY_EN : requester 0 always wins contention.
//   Last_Grant is still kept and reset, but it is unused.

module calculator_arbiter #(
  parameter int DATA_WIDTH = 18
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Req_Valid_0,
  input  logic                  Req_Valid_1,
  input  logic [DATA_WIDTH-1:0] Req_Instruction_0,
  input  logic [DATA_WIDTH-1:0] Req_Instruction_1,
  output logic                  Req_Ready_0,
  output logic                  Req_Ready_1,
  output logic [1:0]            Alu_Operation,
  output logic [7:0]            Alu_Operand_1,
  output logic [7:0]            Alu_Operand_2,
  input  logic [DATA_WIDTH-1:0] Alu_Result,
  output logic                  Resp_Valid_0,
  output logic                  Resp_Valid_1,
  output logic [DATA_WIDTH-1:0] Resp_Result,
  input  logic                  Resp_Ready_0,
  input  logic                  Resp_Ready_1,
  output logic                  Busy
);

  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] op1;
    logic [7:0] op2;
  } alu_req_t;

  logic [NUM_REQ-1:0]                 req_vld, req_rdy, rsp_rdy, grant;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_ins;

  assign req_vld = {Req_Valid_1, Req_Valid_0};
  assign req_ins = {Req_Instruction_1, Req_Instruction_0};
  assign rsp_rdy = {Resp_Ready_1, Resp_Ready_0};

  logic                  iss_vld_q, iss_vld_d;
  logic                  iss_own_q, iss_own_d;
  alu_req_t              iss_q, iss_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic                  rsp_own_q, rsp_own_d;
  logic [DATA_WIDTH-1:0] rsp_res_q, rsp_res_d;
  logic                  last_grant_q, last_grant_d;

  logic                  rsp_accept, issue_adv, slot_free;
  logic                  acc, acc_own;
  logic [DATA_WIDTH-1:0] acc_ins;

  always_comb begin
    rsp_accept = rsp_vld_q & rsp_rdy[rsp_own_q];
    issue_adv  = iss_vld_q & (~rsp_vld_q | rsp_accept);
    slot_free  = ~iss_vld_q | issue_adv;
  end

`ifdef CALC_ARB_FIXED_PRIORITY_EN
  assign grant[0] = req_vld[0];
  assign grant[1] = req_vld[1] & ~req_vld[0];
`else
  // On contention, the requester that did not win last time is granted.
  assign grant[0] = req_vld[0] & (~req_vld[1] | last_grant_q);
  assign grant[1] = req_vld[1] & (~req_vld[0] | ~last_grant_q);
`endif

  // Reset gating keeps Req_Ready low even while the empty stages look free.
  assign req_rdy = grant & {NUM_REQ{slot_free & ~Reset}};
  assign acc     = |(req_vld & req_rdy);
  assign acc_own = req_rdy[1];
  assign acc_ins = req_ins[acc_own];

  always_comb begin
    iss_vld_d    = iss_vld_q;
    iss_own_d    = iss_own_q;
    iss_d        = iss_q;
    rsp_vld_d    = rsp_vld_q;
    rsp_own_d    = rsp_own_q;
    rsp_res_d    = rsp_res_q;
    last_grant_d = last_grant_q;

    if (rsp_accept) rsp_vld_d = 1'b0;
    if (issue_adv) begin
      rsp_vld_d = 1'b1;
      rsp_own_d = iss_own_q;
      rsp_res_d = Alu_Result;
      iss_vld_d = 1'b0;
    end
    // A new accept refills the issue stage in the same cycle as it drains.
    if (acc) begin
      iss_vld_d    = 1'b1;
      iss_own_d    = acc_own;
      iss_d.op     = acc_ins[DATA_WIDTH-1 -: 2];
      iss_d.op1    = acc_ins[15:8];
      iss_d.op2    = acc_ins[7:0];
      last_grant_d = acc_own;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      iss_vld_q    <= 1'b0;
      iss_own_q    <= 1'b0;
      iss_q        <= '0;
      rsp_vld_q    <= 1'b0;
      rsp_own_q    <= 1'b0;
      rsp_res_q    <= '0;
      last_grant_q <= 1'b1;
    end else begin
      iss_vld_q    <= iss_vld_d;
      iss_own_q    <= iss_own_d;
      iss_q        <= iss_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_own_q    <= rsp_own_d;
      rsp_res_q    <= rsp_res_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign Req_Ready_0   = req_rdy[0];
  assign Req_Ready_1   = req_rdy[1];
  assign Alu_Operation = iss_q.op;
  assign Alu_Operand_1 = iss_q.op1;
  assign Alu_Operand_2 = iss_q.op2;
  assign Resp_Valid_0  = rsp_vld_q & ~rsp_own_q;
  assign Resp_Valid_1  = rsp_vld_q & rsp_own_q;
  assign Resp_Result   = rsp_res_q;
  assign Busy          = iss_vld_q | rsp_vld_q;

endmodule

// File: tb/tb_calculator_arbiter.sv
// Scoreboard bench for calculator_arbiter. Drivers present queued directed
// vectors. Each accept pushes {owner, hand-computed result}. A monitor pops
// and compares on every response handshake.

module tb_calculator_arbiter;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Req_Valid_0, Req_Valid_1;
  logic [17:0] Req_Instruction_0, Req_Instruction_1;
  logic        Req_Ready_0, Req_Ready_1;
  logic [1:0]  Alu_Operation;
  logic [7:0]  Alu_Operand_1, Alu_Operand_2;
  logic [17:0] Alu_Result;
  logic        Resp_Valid_0, Resp_Valid_1;
  logic [17:0] Resp_Result;
  logic        Resp_Ready_0, Resp_Ready_1;
  logic        Busy;

  calculator_arbiter #(.DATA_WIDTH(18)) dut (
    .CLK(CLK), .Reset(Reset),
    .Req_Valid_0(Req_Valid_0), .Req_Valid_1(Req_Valid_1),
    .Req_Instruction_0(Req_Instruction_0), .Req_Instruction_1(Req_Instruction_1),
    .Req_Ready_0(Req_Ready_0), .Req_Ready_1(Req_Ready_1),
    .Alu_Operation(Alu_Operation), .Alu_Operand_1(Alu_Operand_1),
    .Alu_Operand_2(Alu_Operand_2), .Alu_Result(Alu_Result),
    .Resp_Valid_0(Resp_Valid_0), .Resp_Valid_1(Resp_Valid_1),
    .Resp_Result(Resp_Result),
    .Resp_Ready_0(Resp_Ready_0), .Resp_Ready_1(Resp_Ready_1),
    .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // ALU model: 0 add, 1 8-bit subtract, 2 and, 3 multiply.
  logic [7:0] sub8;
  assign sub8 = Alu_Operand_1 - Alu_Operand_2;
  always_comb begin
    Alu_Result = '0;
    case (Alu_Operation)
      2'd0: Alu_Result = 18'(Alu_Operand_1) + 18'(Alu_Operand_2);
      2'd1: Alu_Result = 18'(sub8);
      2'd2: Alu_Result = 18'(Alu_Operand_1 & Alu_Operand_2);
      default: Alu_Result = 18'(Alu_Operand_1) * 18'(Alu_Operand_2);
    endcase
  end

  typedef struct packed { logic [17:0] ins; logic [17:0] exp; } vec_t;
  typedef struct packed { logic own; logic [17:0] res; } sb_t;

  vec_t        stim_q0[$], stim_q1[$];
  sb_t         sb_q[$];
  bit          glog[$];
  bit          took0, took1;
  logic [17:0] exp0, exp1;
  int          n_chk = 0, n_err = 0, resp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, req, $time);
    end
  endtask

  // Drivers: hold each vector until accepted, then present the next one.
  initial begin
    vec_t v;
    Req_Valid_0 = 1'b0; Req_Instruction_0 = '0; exp0 = '0;
    forever begin
      @(posedge CLK); #1;
      if (took0) Req_Valid_0 = 1'b0;
      if (!Req_Valid_0 && stim_q0.size() > 0) begin
        v = stim_q0.pop_front();
        Req_Instruction_0 = v.ins; exp0 = v.exp; Req_Valid_0 = 1'b1;
      end
    end
  end

  initial begin
    vec_t v;
    Req_Valid_1 = 1'b0; Req_Instruction_1 = '0; exp1 = '0;
    forever begin
      @(posedge CLK); #1;
      if (took1) Req_Valid_1 = 1'b0;
      if (!Req_Valid_1 && stim_q1.size() > 0) begin
        v = stim_q1.pop_front();
        Req_Instruction_1 = v.ins; exp1 = v.exp; Req_Valid_1 = 1'b1;
      end
    end
  end

  // Monitor: inputs only change at posedge+1, so at negedge a visible
  // handshake is exactly the transfer that happens at the next posedge.
  initial begin
    sb_t e;
    forever begin
      @(negedge CLK);
      took0 = Req_Valid_0 && Req_Ready_0;
      took1 = Req_Valid_1 && Req_Ready_1;
      if (Req_Ready_0 || Req_Ready_1) chk("one_ready", 32'(Req_Ready_0 && Req_Ready_1), 0);
`ifdef CALC_ARB_FIXED_PRIORITY_EN
      if (Req_Ready_1) chk("fixed_r1_only_alone", 32'(Req_Valid_0), 0);
`endif
      if (took0) begin e.own = 1'b0; e.res = exp0; sb_q.push_back(e); glog.push_back(1'b0); end
      if (took1) begin e.own = 1'b1; e.res = exp1; sb_q.push_back(e); glog.push_back(1'b1); end
      if (Resp_Valid_0 || Resp_Valid_1) chk("one_resp", 32'(Resp_Valid_0 && Resp_Valid_1), 0);
      if ((Resp_Valid_0 && Resp_Ready_0) || (Resp_Valid_1 && Resp_Ready_1)) begin
        if (sb_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL stale_resp: got result %0h expected no response @%0t", Resp_Result, $time);
        end else begin
          e = sb_q.pop_front();
          chk("resp_owner", 32'(Resp_Valid_1), 32'(e.own));
          chk("resp_result", 32'(Resp_Result), 32'(e.res));
          resp_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drain(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge CLK); #1; n++;
    end while (n < 60 && (Busy || sb_q.size() != 0 || stim_q0.size() != 0 ||
                          stim_q1.size() != 0 || Req_Valid_0 || Req_Valid_1));
    chk(nm, 32'(n < 60), 1);
  endtask

  initial begin
    int n, cnt, base;
    vec_t v;
    bit exp_g[5];
`ifdef CALC_ARB_FIXED_PRIORITY_EN
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
    Reset = 1'b1; Resp_Ready_0 = 1'b1; Resp_Ready_1 = 1'b1;
    v.ins = 18'h0_05_03; v.exp = 18'd8; stim_q0.push_back(v);

    // Reset state, with requester 0 already presenting
    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_alu", {14'd0, Alu_Operation, Alu_Operand_1, Alu_Operand_2}, 0);
    chk("rst_resp_valid", {Resp_Valid_1, Resp_Valid_0}, 0);
    chk("rst_resp_result", 32'(Resp_Result), 0);
    chk("rst_req_valid_seen", 32'(Req_Valid_0), 1);
    chk("rst_req_ready", {Req_Ready_1, Req_Ready_0}, 0);
    @(posedge CLK); #1 Reset = 1'b0;

    // Single request: accept at N, ALU fields in N+1, response in N+2
    @(negedge CLK);
    n = 0;
    while (!(Req_Valid_0 && Req_Ready_0) && n < 20) begin @(negedge CLK); n++; end
    chk("single_accept", 32'(n < 20), 1);
    @(negedge CLK);
    chk("single_alu_op", 32'(Alu_Operation), 0);
    chk("single_alu_op1", 32'(Alu_Operand_1), 5);
    chk("single_alu_op2", 32'(Alu_Operand_2), 3);
    chk("single_no_early_resp", 32'(Resp_Valid_0), 0);
    @(negedge CLK);
    chk("single_resp_valid0", 32'(Resp_Valid_0), 1);
    chk("single_resp_result", 32'(Resp_Result), 8);
    chk("single_resp_valid1", 32'(Resp_Valid_1), 0);
    @(negedge CLK);
    chk("single_idle", 32'(Busy), 0);

    // Fresh reset so requester 0 wins the first contention
    @(posedge CLK); #1 Reset = 1'b1;
    @(posedge CLK); #1 Reset = 1'b0;
    glog.delete();
    base = resp_cnt;

    // Contention: both present together
    @(negedge CLK);
    v.ins = 18'h0_10_20; v.exp = 18'h30;  stim_q0.push_back(v);
    v.ins = 18'h1_30_10; v.exp = 18'h20;  stim_q0.push_back(v);
    v.ins = 18'h2_F0_3C; v.exp = 18'h30;  stim_q0.push_back(v);
    v.ins = 18'h3_04_05; v.exp = 18'h14;  stim_q1.push_back(v);
    v.ins = 18'h0_FF_FF; v.exp = 18'h1FE; stim_q1.push_back(v);
    drain("contend_drain");
    chk("contend_grants", 32'(glog.size()), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("contend_grant_order", 32'(glog[i]), 32'(exp_g[i]));
    chk("contend_resp_count", 32'(resp_cnt - base), 5);

    // Backpressure on requester 0 with three queued requests
    base = resp_cnt;
    @(posedge CLK); #1 Resp_Ready_0 = 1'b0;
    @(negedge CLK);
    v.ins = 18'h0_01_02; v.exp = 18'h3;  stim_q0.push_back(v);
    v.ins = 18'h1_09_04; v.exp = 18'h5;  stim_q0.push_back(v);
    v.ins = 18'h3_0A_0B; v.exp = 18'h6E; stim_q0.push_back(v);
    n = 0;
    while (!Resp_Valid_0 && n < 20) begin @(negedge CLK); n++; end
    chk("bp_first_result", 32'(n < 20), 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge CLK);
      chk("bp_resp_valid", 32'(Resp_Valid_0), 1);
      chk("bp_resp_result", 32'(Resp_Result), 3);
      chk("bp_alu", {14'd0, Alu_Operation, Alu_Operand_1, Alu_Operand_2}, 32'h1_09_04);
      chk("bp_req_ready", {Req_Ready_1, Req_Ready_0}, 0);
      chk("bp_busy", 32'(Busy), 1);
    end
    @(posedge CLK); #1 Resp_Ready_0 = 1'b1;
    drain("bp_drain");
    chk("bp_resp_count", 32'(resp_cnt - base), 3);

    // Reset with both stages full
    @(posedge CLK); #1 Resp_Ready_1 = 1'b0;
    @(negedge CLK);
    v.ins = 18'h0_01_01; v.exp = 18'h2; stim_q1.push_back(v);
    v.ins = 18'h0_02_02; v.exp = 18'h4; stim_q1.push_back(v);
    n = 0; cnt = 0;
    while (cnt < 2 && n < 20) begin
      @(negedge CLK); n++;
      if (Req_Valid_1 && Req_Ready_1) cnt++;
    end
    chk("rmf_two_accepts", 32'(cnt), 2);
    @(negedge CLK);
    chk("rmf_full_busy", 32'(Busy), 1);
    chk("rmf_full_resp", 32'(Resp_Valid_1), 1);
    chk("rmf_full_stall", 32'(Req_Ready_1), 0);
    #2 Reset = 1'b1;
    sb_q.delete();
    #1;
    chk("rmf_valids", {Resp_Valid_1, Resp_Valid_0, Req_Ready_1, Req_Ready_0}, 0);
    chk("rmf_alu", {14'd0, Alu_Operation, Alu_Operand_1, Alu_Operand_2}, 0);
    chk("rmf_busy", 32'(Busy), 0);
    chk("rmf_resp_result", 32'(Resp_Result), 0);
    @(posedge CLK); #1 Resp_Ready_1 = 1'b1;
    @(posedge CLK); #1 Reset = 1'b0;
    repeat (5) @(negedge CLK);
    chk("rmf_no_stale", {Resp_Valid_1, Resp_Valid_0}, 0);
    chk("rmf_idle", 32'(Busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
